// File: rtl/write_dma_packer_if.sv
// Memory-write bus between the packer (master) and the Switch/external_memory side (slave).
interface write_dma_packer_if;
    logic        HREADY;
    logic [1:0]  o_HTRANS;
    logic [31:0] mem_WR_addr;
    logic        mem_write_flag;
    logic [31:0] HWDATA_toMem;

    modport master (
        input  HREADY,
        output o_HTRANS, mem_WR_addr, mem_write_flag, HWDATA_toMem
    );

    modport slave (
        output HREADY,
        input  o_HTRANS, mem_WR_addr, mem_write_flag, HWDATA_toMem
    );
endinterface

// File: rtl/write_dma_packer.sv
// Packs the received byte stream into little-endian 32-bit words, buffers them in a small FIFO
// and writes them to consecutive addresses of the armed DMA region as a bus master.
module write_dma_packer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_STRIDE = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    i_WriteSystemStart,
    input  logic [7:0]              i_serialized_input,
    input  logic                    i_serialized_input_vld,
    input  logic [5:0]              i_RCC_BUFFER_LENGTH,
    input  logic [15:0]             i_RCC_DMA_ADDR_HIGH,
    input  logic [15:0]             i_RCC_DMA_ADDR_LOW,
    write_dma_packer_if.master      bus,
    output logic                    slave_done,
    output logic                    o_busy,
    output logic [15:0]             o_Bytes_Counter,
    output logic [1:0]              o_Deserialize_Counter,
    output logic                    o_overflow
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = 7;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_busy;
    logic [LW-1:0]   r_len, r_pk_cnt;
    logic [31:0]     r_next_addr;
    logic [1:0]      r_lane;
    logic [23:0]     r_word;
    logic [15:0]     r_bytes;
    logic            r_ovf;
    logic [31:0]     r_fifo [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_wr_flag, r_done;
    logic [31:0]     r_addr, r_data;

    logic            w_start, w_accept, w_word_done, w_full, w_empty, w_pop, w_push, w_last;
    logic [31:0]     w_word;
    logic [1:0]      w_htrans;

    assign w_start     = i_WriteSystemStart && (r_state == S_IDLE) && !r_busy;
    assign w_accept    = r_busy && i_serialized_input_vld && (r_pk_cnt < r_len);
    assign w_word_done = w_accept && (r_lane == 2'd3);
    assign w_word      = {i_serialized_input, r_word};
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop       = (r_state == S_REQ) && !w_empty && bus.HREADY;
    assign w_push      = w_word_done && (!w_full || w_pop);
    // All packed words accounted for and nothing left to drain (dropped words never get written).
    assign w_last      = (r_pk_cnt == r_len) && w_empty;

    // Bus FSM next state and bus request
    always_comb begin
        w_state_nxt = r_state;
        w_htrans    = 2'b00;
        case (r_state)
            S_IDLE:  if (r_busy) w_state_nxt = S_REQ;
            S_REQ: begin
                if (!w_empty) w_htrans = 2'b10;
                if (w_pop) w_state_nxt = S_WRITE;
            end
            S_WRITE: w_state_nxt = w_last ? S_DONE : S_REQ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Transfer control, byte packing and FIFO bookkeeping
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_busy      <= 1'b0;
            r_len       <= '0;
            r_pk_cnt    <= '0;
            r_next_addr <= '0;
            r_lane      <= '0;
            r_word      <= '0;
            r_bytes     <= '0;
            r_ovf       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_wr_flag   <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_start) begin
                r_busy      <= 1'b1;
                r_len       <= (i_RCC_BUFFER_LENGTH == 6'd0) ? LW'(64) : LW'(i_RCC_BUFFER_LENGTH);
                r_pk_cnt    <= '0;
                r_next_addr <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW};
                r_lane      <= '0;
                r_word      <= '0;
                r_bytes     <= '0;
                r_ovf       <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end

            if (w_accept) begin
                r_lane  <= r_lane + 2'd1;
                r_bytes <= r_bytes + 16'd1;
                case (r_lane)
                    2'd0:    r_word[7:0]   <= i_serialized_input;
                    2'd1:    r_word[15:8]  <= i_serialized_input;
                    2'd2:    r_word[23:16] <= i_serialized_input;
                    default: r_word        <= r_word;
                endcase
            end
            if (w_word_done) begin
                r_pk_cnt <= r_pk_cnt + LW'(1);
                if (!w_push) r_ovf <= 1'b1;
            end

            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            r_wr_flag <= w_pop;
            if (w_pop) begin
                r_addr      <= r_next_addr;
                r_data      <= r_fifo[r_rptr];
                r_next_addr <= r_next_addr + 32'(ADDR_STRIDE);
            end
            r_done <= (r_state == S_WRITE) && w_last;
        end
    end

    // Word storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge HCLK) begin
        if (w_push) r_fifo[r_wptr] <= w_word;
    end

    assign bus.o_HTRANS       = w_htrans;
    assign bus.mem_WR_addr    = r_addr;
    assign bus.mem_write_flag = r_wr_flag;
    assign bus.HWDATA_toMem   = r_data;
    assign slave_done            = r_done;
    assign o_busy                = r_busy;
    assign o_Bytes_Counter       = r_bytes;
    assign o_Deserialize_Counter = r_lane;
    assign o_overflow            = r_ovf;
endmodule
